// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction-memory req/ack read channel
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction fetch unit
module pc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic              execute,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  pc_fetch_if.master        imem,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              stall,
  output logic              fetch_fault,
  output logic              misalign_fault
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [7:0]  WCNT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE,
    REQ
  } state_t;

  state_t      state;
  logic [31:0] npc;
  logic [31:0] addr_q;
  logic        req_q;
  logic [7:0]  wcnt;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign pc_plus4       = pc + 32'd4;
  assign stall          = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      npc            <= RESET_PC;
      addr_q         <= RESET_PC;
      req_q          <= 1'b0;
      instruction    <= NOP;
      instr_valid    <= 1'b0;
      fetch_fault    <= 1'b0;
      misalign_fault <= 1'b0;
      wcnt           <= 8'd0;
    end else begin
      misalign_fault <= 1'b0;
      case (state)
        IDLE: begin
          // Redirect only lands on npc; a simultaneous fetch still uses the old npc.
          if (execute && redirect_valid) begin
            npc            <= {redirect_target[31:2], 2'b00};
            misalign_fault <= |redirect_target[1:0];
          end
          if (fetch) begin
            pc          <= npc;
            addr_q      <= npc;
            req_q       <= 1'b1;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            wcnt        <= 8'd0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (imem.imem_ack) begin
            instruction <= imem.imem_rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            npc         <= pc + 32'd4;
            state       <= IDLE;
          end else if (wcnt == WCNT_LAST) begin
            // Timed out: hand the flow controller a NOP so it can keep moving.
            instruction <= NOP;
            instr_valid <= 1'b1;
            fetch_fault <= 1'b1;
            req_q       <= 1'b0;
            npc         <= pc + 32'd4;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch unit that sits directly upstream of the multi-cycle flow controller. It holds the PC, runs a req/ack read against instruction memory on each `fetch` phase strobe, and latches the returned word into the instruction register. That register drives the `instruction` input of the flow controller and of the decoder. During `execute` it accepts a branch/jump redirect that selects the next PC. It raises `stall` so the flow controller holds in FETCH while memory is slow.

## Interface
- `RESET_PC`, 32'h0000_0000: address of the first fetched instruction; must be word-aligned.
- `ACK_TIMEOUT`, 16: maximum number of req cycles without ack before a fetch fault; legal range 1–255.
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch`  in  1  fetch phase strobe from the flow controller.
- `execute`  in  1  execute phase strobe from the flow controller.
- `redirect_valid`  in  1  the current instruction changes control flow (taken branch, jal).
- `redirect_target`  in  32  next-PC target for the redirect.
- `imem_req`  out  1  instruction-memory read request.
- `imem_addr`  out  32  read address; stable while `imem_req`=1.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  read data.
- `instruction`  out  32  instruction register.
- `instr_valid`  out  1  `instruction` holds the word for the current `pc`.
- `pc`  out  32  address of the instruction in `instruction`.
- `pc_plus4`  out  32  `pc`+4, combinational; used as the link address.
- `stall`  out  1  fetch in progress; flow controller holds in FETCH.
- `fetch_fault`  out  1  sticky; the last fetch timed out.
- `misalign_fault`  out  1  one-cycle pulse; a redirect target was not word-aligned.

## Operation
- Registers: `pc`, `npc`, `instruction`, `instr_valid`, `imem_addr`, `imem_req`, `fetch_fault`, `misalign_fault`, wait counter `wcnt` (8 bits), state ∈ {IDLE, REQ}.
- Reset values (applied asynchronously):
  - `pc` = `npc` = `imem_addr` = `RESET_PC`
  - `instruction` = 32'h0000_0013 (NOP)
  - `instr_valid` = `imem_req` = `fetch_fault` = `misalign_fault` = 0
  - `wcnt` = 0, state = IDLE
- IDLE, `fetch`=1:
  - `pc` <= `npc`; `imem_addr` <= `npc`; `imem_req` <= 1.
  - `instr_valid` <= 0; `fetch_fault` <= 0; `wcnt` <= 0.
  - state <= REQ.
- REQ, `imem_ack`=1:
  - `instruction` <= `imem_rdata`; `instr_valid` <= 1; `imem_req` <= 0.
  - `npc` <= `pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - state <= IDLE.
- REQ, no ack, `wcnt` = `ACK_TIMEOUT`-1:
  - `instruction` <= NOP; `instr_valid` <= 1; `fetch_fault` <= 1.
  - `imem_req` <= 0; `npc` <= `pc`+4; state <= IDLE.
- REQ, no ack, otherwise: `wcnt` <= `wcnt`+1; `imem_req` and `imem_addr` held.
- Redirect: in IDLE with `execute`=1 and `redirect_valid`=1:
  - `npc` <= {`redirect_target`[31:2], 2'b00}.
  - `misalign_fault` <= |`redirect_target`[1:0] for one cycle; otherwise it returns to 0 every cycle.
- Redirect overrides the `pc`+4 written at fetch completion. The last redirect before the next `fetch` wins.
- `stall` = (state == REQ), combinational.
- Ignored events:
  - `fetch` while in REQ.
  - `execute`/redirect while in REQ (protocol error).
  - `imem_ack` while in IDLE.
  - `redirect_valid` without `execute`.
- `fetch` and `execute` both high in IDLE: the fetch uses the old `npc`, and the redirect is still written to `npc`. The flow controller never does this.

## Timing
- `fetch` sampled at edge E0: `imem_req`=1 and `imem_addr`=`npc` from after E0; `stall`=1 from after E0.
- Zero-wait memory (ack in the first req cycle, sampled at E1): `instruction` and `instr_valid` updated after E1; `stall`=0 after E1. Fetch latency is 2 edges.
- N wait cycles: `instr_valid` rises after edge E(1+N).
- Timeout: req stays high for exactly `ACK_TIMEOUT` cycles. An ack at the final edge wins over the timeout.
- Redirect sampled at the edge where `execute`=1; it is visible as `imem_addr` on the next fetch.
- Reset mid-REQ: `imem_req` drops immediately on `rst_n` low. A late ack after release is ignored, because the state is IDLE.

## Test plan
- Reset release, `fetch` pulse, memory acks the same cycle with 32'h00500093 → `imem_addr`=0, `instruction`=32'h00500093, `pc`=0, `instr_valid` 2 edges after `fetch`; next fetch address is 4.
- Ack after 3 wait cycles → `stall` high for 4 cycles, `imem_addr` stable throughout, `instr_valid` at E4.
- `execute` with `redirect_valid`, target 32'h0000_0040 → next fetch address 32'h40; target 32'h43 → address 32'h40 and one `misalign_fault` pulse.
- No ack, `ACK_TIMEOUT`=16 → req high for 16 cycles, then `instruction`=NOP, `fetch_fault`=1; it clears on the next `fetch`.
- `npc`=32'hFFFF_FFFC fetch → next address 32'h0; `fetch` during REQ → no second request.
- `rst_n` low during REQ → `imem_req`=0 immediately; an ack after release has no effect and `pc`=`RESET_PC`.
